// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path.
//   rx_state_t  : receiver FSM states
//   STATUS_W    : number of status bits stored with each received word
//   entry_width : width of one FIFO entry, {frame_err, parity_err, data}
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2
    } rx_state_t;

    localparam int STATUS_W = 2;

    function automatic int entry_width(input int data_width);
        return data_width + STATUS_W;
    endfunction

endpackage

// File: rtl/uart_rx_sync_fifo.sv
// Show-ahead synchronous FIFO for received UART words.
//   clk, reset : clock and synchronous active-high reset (empties the FIFO)
//   wr_en      : write request; accepted when not full, or when full with a
//                same-cycle read freeing a slot
//   wr_data    : entry to write
//   rd_en      : read request; honoured only when not empty
//   rd_data    : head entry, valid with no latency; all zeros when empty
//   empty/full : occupancy flags
//   count      : current number of entries
module uart_rx_sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = rd_en & ~empty;
    assign do_push = wr_en & (~full | do_pop);

    // Pointers are exactly AW bits wide, so increments wrap modulo DEPTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

    // Storage is not cleared, so the head is masked while empty.
    assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/uart_rx_fifo_core.sv
// UART receiver with oversampled majority voting and a receive FIFO.
//   UCLK            : sole clock, rising edge
//   reset           : synchronous active-high reset
//   serial_data_in  : asynchronous serial line, idle high
//   prescale        : UCLK cycles per bit (even, 8..32), latched per frame
//   parity_enable   : parity bit present; parity_type 0 even / 1 odd
//   two_stop_bits   : expect two stop bits
//   rd_ready        : consumer pops the head entry when rd_valid
//   overrun_clear   : clears the sticky overrun flag
//   rd_valid        : FIFO not empty
//   rd_data, rd_parity_error, rd_frame_error : head entry
//   overrun         : sticky, a frame was dropped because the FIFO was full
//   break_detect    : one-cycle pulse when a break frame is pushed
//   fifo_count      : FIFO occupancy
module uart_rx_fifo_core
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          UCLK,
    input  logic                          reset,
    input  logic                          serial_data_in,
    input  logic [5:0]                    prescale,
    input  logic                          parity_enable,
    input  logic                          parity_type,
    input  logic                          two_stop_bits,
    input  logic                          rd_ready,
    input  logic                          overrun_clear,
    output logic                          rd_valid,
    output logic [DATA_WIDTH-1:0]         rd_data,
    output logic                          rd_parity_error,
    output logic                          rd_frame_error,
    output logic                          overrun,
    output logic                          break_detect,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int         ENTRY_W  = entry_width(DATA_WIDTH);
    localparam logic [3:0] LAST_BIT = 4'(DATA_WIDTH - 1);

    rx_state_t state_q, state_d;

    logic                  rx_sync_p0, rx_sync_p1, rx_prev;
    logic                  fall_edge;
    logic [5:0]            cnt_q, bit_idx_pad;
    logic [3:0]            bit_idx_q;
    logic [5:0]            presc_q, half;
    logic                  par_en_q, par_type_q, two_stop_q;
    logic                  samp_a_q, samp_b_q, maj;
    logic                  at_first, at_mid, at_resolve, at_wrap;
    logic [DATA_WIDTH-1:0] shift_q;
    logic                  par_bit_q, stop1_q, frame_err_q;
    logic                  stop1_val, frame_err_d, parity_err_d, is_break;
    logic                  frame_push;
    logic [ENTRY_W-1:0]    push_entry, head_entry;
    logic                  fifo_full, fifo_empty, pop;

    assign bit_idx_pad = {2'b00, bit_idx_q};

    // Synchroniser stage boundary: two flops, then one more for edge detect.
    always_ff @(posedge UCLK) begin
        if (reset) begin
            rx_sync_p0 <= 1'b1;
            rx_sync_p1 <= 1'b1;
            rx_prev    <= 1'b1;
        end else begin
            rx_sync_p0 <= serial_data_in;
            rx_sync_p1 <= rx_sync_p0;
            rx_prev    <= rx_sync_p1;
        end
    end

    assign fall_edge = rx_prev & ~rx_sync_p1;

    assign half       = {1'b0, presc_q[5:1]};
    assign at_first   = (cnt_q == half - 6'd1);
    assign at_mid     = (cnt_q == half);
    assign at_resolve = (cnt_q == half + 6'd1);
    assign at_wrap    = (cnt_q == presc_q - 6'd1);
    assign maj        = (samp_a_q & samp_b_q) | (samp_a_q & rx_sync_p1) | (samp_b_q & rx_sync_p1);

    always_ff @(posedge UCLK) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // The final stop bit pushes and returns to IDLE at its resolve point so a
    // following start edge is never missed.
    always_comb begin
        state_d    = state_q;
        frame_push = 1'b0;
        case (state_q)
            IDLE:   if (fall_edge) state_d = START;
            START: begin
                if (at_resolve && maj) state_d = IDLE;
                else if (at_wrap)      state_d = DATA;
            end
            DATA:   if (at_wrap && bit_idx_pad == {2'b00, LAST_BIT})
                        state_d = par_en_q ? PARITY : STOP1;
            PARITY: if (at_wrap) state_d = STOP1;
            STOP1: begin
                if (two_stop_q) begin
                    if (at_wrap) state_d = STOP2;
                end else if (at_resolve) begin
                    frame_push = 1'b1;
                    state_d    = IDLE;
                end
            end
            STOP2: if (at_resolve) begin
                frame_push = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Bit timing and per-frame configuration.
    always_ff @(posedge UCLK) begin
        if (reset) begin
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            presc_q    <= 6'd16;
            par_en_q   <= 1'b0;
            par_type_q <= 1'b0;
            two_stop_q <= 1'b0;
        end else if (state_q == IDLE) begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            if (fall_edge) begin
                presc_q    <= prescale;
                par_en_q   <= parity_enable;
                par_type_q <= parity_type;
                two_stop_q <= two_stop_bits;
            end
        end else begin
            cnt_q <= at_wrap ? 6'd0 : cnt_q + 6'd1;
            if (at_wrap && state_q == DATA) bit_idx_q <= bit_idx_q + 4'd1;
        end
    end

    // Sample stage boundary: two early samples held, third taken live at resolve.
    always_ff @(posedge UCLK) begin
        if (at_first) samp_a_q <= rx_sync_p1;
        if (at_mid)   samp_b_q <= rx_sync_p1;
        if (state_q == IDLE) frame_err_q <= 1'b0;
        if (at_resolve) begin
            case (state_q)
                DATA:    shift_q   <= {maj, shift_q[DATA_WIDTH-1:1]};
                PARITY:  par_bit_q <= maj;
                STOP1: begin
                    stop1_q <= maj;
                    if (!maj) frame_err_q <= 1'b1;
                end
                STOP2:   if (!maj) frame_err_q <= 1'b1;
                default: ;
            endcase
        end
    end

    assign stop1_val    = (state_q == STOP1) ? maj : stop1_q;
    assign frame_err_d  = frame_err_q | ~maj;
    assign parity_err_d = par_en_q & (((^shift_q) ^ par_bit_q) != par_type_q);
    assign is_break     = (shift_q == '0) & (~par_en_q | ~par_bit_q) & ~stop1_val;
    assign push_entry   = {frame_err_d, parity_err_d, shift_q};

    uart_rx_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (UCLK),
        .reset   (reset),
        .wr_en   (frame_push),
        .wr_data (push_entry),
        .rd_en   (rd_ready),
        .rd_data (head_entry),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .count   (fifo_count)
    );

    assign rd_valid = ~fifo_empty;
    assign pop      = rd_ready & rd_valid;
    assign {rd_frame_error, rd_parity_error, rd_data} = head_entry;

    // Status stage boundary: a set in the same cycle as a clear wins.
    always_ff @(posedge UCLK) begin
        if (reset) begin
            overrun      <= 1'b0;
            break_detect <= 1'b0;
        end else begin
            if (frame_push && fifo_full && !pop) overrun <= 1'b1;
            else if (overrun_clear)              overrun <= 1'b0;
            break_detect <= frame_push & is_break;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo_core.sv
module tb_uart_rx_fifo_core;

    localparam int DW = 8;
    localparam int FD = 4;
    localparam int CW = $clog2(FD) + 1;

    logic          UCLK = 1'b0;
    logic          reset = 1'b0;
    logic          serial_data_in = 1'b1;
    logic [5:0]    prescale = 6'd16;
    logic          parity_enable = 1'b0;
    logic          parity_type = 1'b0;
    logic          two_stop_bits = 1'b0;
    logic          rd_ready = 1'b0;
    logic          overrun_clear = 1'b0;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          rd_parity_error;
    logic          rd_frame_error;
    logic          overrun;
    logic          break_detect;
    logic [CW-1:0] fifo_count;

    uart_rx_fifo_core #(.DATA_WIDTH(DW), .FIFO_DEPTH(FD)) dut (
        .UCLK            (UCLK),
        .reset           (reset),
        .serial_data_in  (serial_data_in),
        .prescale        (prescale),
        .parity_enable   (parity_enable),
        .parity_type     (parity_type),
        .two_stop_bits   (two_stop_bits),
        .rd_ready        (rd_ready),
        .overrun_clear   (overrun_clear),
        .rd_valid        (rd_valid),
        .rd_data         (rd_data),
        .rd_parity_error (rd_parity_error),
        .rd_frame_error  (rd_frame_error),
        .overrun         (overrun),
        .break_detect    (break_detect),
        .fifo_count      (fifo_count)
    );

    always #5 UCLK = ~UCLK;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model: FIFO contents as a queue of {frame_err, parity_err, data}.
    logic [DW+1:0] exp_q[$];
    bit            exp_ovr = 1'b0;
    int            exp_breaks = 0;
    int            seen_breaks = 0;
    int            long_breaks = 0;
    bit            brk_prev = 1'b0;

    always @(negedge UCLK) begin
        if (break_detect) seen_breaks++;
        if (break_detect && brk_prev) long_breaks++;
        brk_prev = break_detect;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_cmp++;
        if (obs !== want) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, want);
        end
    endtask

    task automatic tick();
        @(posedge UCLK);
        #1;
    endtask

    task automatic drive_bit(input logic v, input int p);
        serial_data_in = v;
        repeat (p) tick();
    endtask

    task automatic model_push(input logic [DW+1:0] e);
        if (exp_q.size() < FD) exp_q.push_back(e);
        else                   exp_ovr = 1'b1;
    endtask

    task automatic send_frame(input logic [DW-1:0] d, input int p, input bit pen, input bit ptype,
                              input bit two, input bit pflip, input bit s1, input bit s2);
        bit pbit, fe, pe, brk;
        prescale      = 6'(p);
        parity_enable = pen;
        parity_type   = ptype;
        two_stop_bits = two;
        drive_bit(1'b1, 4);
        pbit = (^d) ^ ptype ^ pflip;
        drive_bit(1'b0, p);
        for (int i = 0; i < DW; i++) drive_bit(d[i], p);
        if (pen) drive_bit(pbit, p);
        drive_bit(s1, p);
        if (two) drive_bit(s2, p);
        drive_bit(1'b1, p);
        pe  = pen && (((^d) ^ pbit) != ptype);
        fe  = !s1 || (two && !s2);
        brk = (d == '0) && (!pen || !pbit) && !s1;
        model_push({fe, pe, d});
        if (brk) exp_breaks++;
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".count"}, 32'(fifo_count), 32'(exp_q.size()));
        chk({tag, ".valid"}, 32'(rd_valid), 32'(exp_q.size() != 0));
        chk({tag, ".overrun"}, 32'(overrun), 32'(exp_ovr));
        chk({tag, ".breaks"}, 32'(seen_breaks), 32'(exp_breaks));
        chk({tag, ".brk_width"}, 32'(long_breaks), 32'd0);
        if (exp_q.size() != 0) begin
            chk({tag, ".data"}, 32'(rd_data), 32'(exp_q[0][DW-1:0]));
            chk({tag, ".perr"}, 32'(rd_parity_error), 32'(exp_q[0][DW]));
            chk({tag, ".ferr"}, 32'(rd_frame_error), 32'(exp_q[0][DW+1]));
        end else begin
            chk({tag, ".data_empty"}, 32'(rd_data), 32'd0);
        end
    endtask

    task automatic pop_one(input string tag);
        if (exp_q.size() != 0) begin
            chk({tag, ".pop_data"}, 32'(rd_data), 32'(exp_q[0][DW-1:0]));
            chk({tag, ".pop_perr"}, 32'(rd_parity_error), 32'(exp_q[0][DW]));
            chk({tag, ".pop_ferr"}, 32'(rd_frame_error), 32'(exp_q[0][DW+1]));
            rd_ready = 1'b1;
            tick();
            rd_ready = 1'b0;
            void'(exp_q.pop_front());
            chk({tag, ".pop_count"}, 32'(fifo_count), 32'(exp_q.size()));
        end
    endtask

    task automatic clear_overrun(input string tag);
        overrun_clear = 1'b1;
        tick();
        overrun_clear = 1'b0;
        exp_ovr = 1'b0;
        chk({tag, ".ovr_clear"}, 32'(overrun), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        serial_data_in = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        exp_q.delete();
        exp_ovr = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] b;
        int p, npop;

        do_reset();
        chk("rst.valid", 32'(rd_valid), 32'd0);
        chk("rst.data", 32'(rd_data), 32'd0);
        chk("rst.perr", 32'(rd_parity_error), 32'd0);
        chk("rst.ferr", 32'(rd_frame_error), 32'd0);
        chk("rst.overrun", 32'(overrun), 32'd0);
        chk("rst.break", 32'(break_detect), 32'd0);
        chk("rst.count", 32'(fifo_count), 32'd0);

        // 8N1 0xA5 at prescale 16
        send_frame(8'hA5, 16, 0, 0, 0, 0, 1, 1);
        chk("a5.count", 32'(fifo_count), 32'd1);
        chk("a5.data", 32'(rd_data), 32'hA5);
        check_state("a5");
        pop_one("a5");

        // 8E1 0x03 with parity bit forced to 1
        send_frame(8'h03, 16, 1, 0, 0, 1, 1, 1);
        chk("par.perr", 32'(rd_parity_error), 32'd1);
        check_state("par");
        pop_one("par");

        // 4-cycle low glitch must be rejected, then a real frame decodes
        serial_data_in = 1'b0;
        repeat (4) tick();
        serial_data_in = 1'b1;
        repeat (40) tick();
        chk("glitch.count", 32'(fifo_count), 32'd0);
        send_frame(8'h3C, 16, 0, 0, 0, 0, 1, 1);
        check_state("glitch_after");
        pop_one("glitch_after");

        // Overrun: five frames, no reads
        for (int i = 0; i < 5; i++) begin
            b = 8'($urandom);
            send_frame(b, 16, 0, 0, 0, 0, 1, 1);
        end
        chk("ovr.count", 32'(fifo_count), 32'd4);
        chk("ovr.flag", 32'(overrun), 32'd1);
        check_state("ovr");
        for (int i = 0; i < 4; i++) pop_one("ovr");
        clear_overrun("ovr");

        // Break: line low for 12 bit times at 8N1
        prescale = 6'd16;
        parity_enable = 1'b0;
        two_stop_bits = 1'b0;
        drive_bit(1'b0, 12 * 16);
        drive_bit(1'b1, 32);
        model_push({1'b1, 1'b0, 8'h00});
        exp_breaks++;
        chk("brk.ferr", 32'(rd_frame_error), 32'd1);
        check_state("brk");
        pop_one("brk");

        // 8O2 with second stop low, then reset in the middle of the next frame
        send_frame(8'h7E, 16, 1, 1, 1, 0, 1, 0);
        chk("stop2.ferr", 32'(rd_frame_error), 32'd1);
        check_state("stop2");
        drive_bit(1'b0, 16);
        drive_bit(1'b1, 16);
        drive_bit(1'b0, 16);
        drive_bit(1'b1, 8);
        reset = 1'b1;
        serial_data_in = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        exp_q.delete();
        exp_ovr = 1'b0;
        repeat (12 * 16) tick();
        chk("midrst.count", 32'(fifo_count), 32'd0);
        check_state("midrst");

        // Randomised frames, configurations, corruptions and reads
        for (int it = 0; it < 30; it++) begin
            p = 2 * int'($urandom_range(4, 16));
            b = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
            send_frame(b, p, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
                       $urandom_range(0, 4) != 0, $urandom_range(0, 4) != 0);
            check_state("rnd");
            npop = int'($urandom_range(0, exp_q.size()));
            if (it % 7 == 6) npop = 0;
            for (int k = 0; k < npop; k++) pop_one("rnd");
            if (exp_ovr && $urandom_range(0, 1) == 1) clear_overrun("rnd");
        end
        while (exp_q.size() != 0) pop_one("drain");
        check_state("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
